// File: rtl/srt4_pkg.sv
// srt4_pkg: shared state, digit and strobe-index definitions for the SRT radix-4 sequencer.
package srt4_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_NCHK, S_NSH, S_DSEL, S_SHIFT, S_ADD,
    S_CCHK, S_CORR, S_QSUB, S_DN_P, S_DN_G, S_DONE, S_ERR
  } state_t;
  typedef enum logic [2:0] {
    D_M2 = 3'b110, D_M1 = 3'b111, D_Z = 3'b000, D_P1 = 3'b001, D_P2 = 3'b010
  } digit_t;
  localparam int C0 = 0, C1 = 1, C2 = 2, C3 = 3, C4 = 4, C5 = 5, C6 = 6, C7 = 7;
  localparam int C8 = 8, C9 = 9, C10 = 10, C11 = 11, C12 = 12, C13 = 13, C14 = 14;
  localparam int N_ITER = 4;
endpackage

// File: rtl/srt4_digit_sel.sv
// srt4_digit_sel: maps signed P[8:5] to a radix-4 digit and its qualifier/adder-select strobes.
module srt4_digit_sel
  import srt4_pkg::*;
(
  input  logic [3:0]  i_p_top,
  output digit_t      o_digit,
  output logic [14:0] o_qual
);
  logic signed [3:0] w_v;
  assign w_v = i_p_top;
  always_comb begin
    o_digit = w_v > 4'sd1 ? D_P2 : w_v == 4'sd1 ? D_P1 : w_v > -4'sd2 ? D_Z :
              w_v == -4'sd2 ? D_M1 : D_M2;
    o_qual = '0;
    o_qual[C4] = o_digit == D_P1;
    o_qual[C5] = o_digit == D_M1;
    o_qual[C6] = o_digit == D_M2;
    o_qual[C7] = o_digit == D_P2;
    o_qual[C9] = o_digit == D_P1 || o_digit == D_P2;
    o_qual[C10] = o_digit == D_M1 || o_digit == D_M2;
    o_qual[C11] = o_digit == D_P2 || o_digit == D_M2;
  end
endmodule

// File: rtl/srt4_ctrl.sv
// srt4_ctrl: strobe sequencer for the SRT radix-4 8-bit divider datapath.
// SRT4_CTRL_DENORM_EN adds the DN_P/DN_G remainder denormalization loop.
module srt4_ctrl
  import srt4_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  p_top,
  input  logic        b_msb,
  input  logic        b_zero,
  output logic [14:0] c,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [2:0]  norm_k
);
  state_t      r_state, w_next;
  digit_t      r_digit, w_digit_n, w_sel_digit;
  logic [14:0] r_qual, w_qual_n, w_sel_qual;
  logic [14:0] r_c, w_c_n;
  logic [2:0]  r_k, w_k_n;
  logic [1:0]  r_iter, w_iter_n;
  logic        r_busy, r_done, r_dbz, w_end;

  srt4_digit_sel u_sel (.i_p_top(p_top), .o_digit(w_sel_digit), .o_qual(w_sel_qual));

  always_comb begin
    w_next = r_state;
    w_k_n = r_k;
    w_iter_n = r_iter;
    w_digit_n = r_digit;
    w_qual_n = r_qual;
    w_end = r_state == S_ADD || (r_state == S_SHIFT && r_digit == D_Z);
    case (r_state)
      S_IDLE:  w_next = start ? S_INIT : S_IDLE;
      S_INIT:  begin w_k_n = '0; w_next = S_NCHK; end
      S_NCHK: begin
        w_iter_n = '0;
        w_next = b_zero ? S_ERR : (!b_msb && r_k != 3'd7) ? S_NSH : S_DSEL;
      end
      S_NSH:   begin w_k_n = r_k + 3'd1; w_next = S_NCHK; end
      S_DSEL:  w_next = S_SHIFT;
      S_SHIFT: w_next = S_ADD;
      S_CCHK:  w_next = p_top[3] ? S_CORR : S_QSUB;
      S_CORR:  w_next = S_QSUB;
`ifdef SRT4_CTRL_DENORM_EN
      S_QSUB:  w_next = r_k != 3'd0 ? S_DN_P : S_DONE;
      S_DN_P:  w_next = S_DN_G;
      S_DN_G:  begin w_k_n = r_k - 3'd1; w_next = r_k == 3'd1 ? S_DONE : S_DN_P; end
`else
      S_QSUB:  w_next = S_DONE;
`endif
      default: w_next = S_IDLE;
    endcase
    // Zero-digit SHIFT and every ADD close the iteration in the same cycle.
    if (w_end) begin
      w_next = r_iter == 2'(N_ITER - 1) ? S_CCHK : S_DSEL;
      w_iter_n = r_iter + 2'd1;
    end
    if (w_next == S_DSEL) begin
      w_digit_n = w_sel_digit;
      w_qual_n = w_sel_qual;
    end
    w_c_n = '0;
    case (w_next)
      S_INIT:  begin w_c_n[C0] = 1'b1; w_c_n[C1] = 1'b1; end
      S_NSH:   w_c_n[C2] = 1'b1;
      S_DSEL:  w_c_n = w_qual_n;
      S_SHIFT: begin w_c_n = w_qual_n; w_c_n[C3] = 1'b1; end
      S_ADD:   begin w_c_n = w_qual_n; w_c_n[C8] = 1'b1; end
      S_CORR:  begin w_c_n[C8] = 1'b1; w_c_n[C10] = 1'b1; w_c_n[C12] = 1'b1; end
      S_QSUB:  w_c_n[C13] = 1'b1;
      S_DN_P:  w_c_n[C14] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_digit <= D_Z;
      r_qual <= '0;
      r_c <= '0;
      r_k <= '0;
      r_iter <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dbz <= 1'b0;
    end else begin
      r_state <= w_next;
      r_digit <= w_digit_n;
      r_qual <= w_qual_n;
      r_c <= w_c_n;
      r_k <= w_k_n;
      r_iter <= w_iter_n;
      r_busy <= w_next != S_IDLE;
      r_done <= w_next == S_DONE || w_next == S_ERR;
      r_dbz <= w_next == S_ERR;
    end
  end

  assign c = r_c;
  assign busy = r_busy;
  assign done = r_done;
  assign div_by_zero = r_dbz;
  assign norm_k = r_k;
endmodule
